// File: rtl/gauss_instr_gen.sv
// Emits the MUL/ADD/END instruction stream for the 5-tap Gaussian filter over a valid/ready port.
// Optional GAUSS_INSTR_PARITY_EN adds a registered even-parity output instr_par.
module gauss_instr_gen #(
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned IMM_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              n_pix,
  input  logic                    abort,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [OPCODE_WIDTH-1:0] instr_opcode,
  output logic [IMM_WIDTH-1:0]    instr_imm,
`ifdef GAUSS_INSTR_PARITY_EN
  output logic                    instr_par,
`endif
  output logic                    busy,
  output logic                    done
);

  localparam logic [OPCODE_WIDTH-1:0] OpMul = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OpAdd = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OpEnd = OPCODE_WIDTH'(3);

  typedef enum logic [2:0] {StIdle, StMul, StAdd, StEnd, StDone} state_t;

`ifdef GAUSS_INSTR_PARITY_EN
  typedef struct packed {
    logic                    par;
    logic [OPCODE_WIDTH-1:0] op;
    logic [IMM_WIDTH-1:0]    imm;
  } instr_t;
`else
  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] op;
    logic [IMM_WIDTH-1:0]    imm;
  } instr_t;
`endif

  function automatic logic [IMM_WIDTH-1:0] coef(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd4: coef = IMM_WIDTH'(8'd17);
      3'd1, 3'd3: coef = IMM_WIDTH'(8'd29);
      3'd2:       coef = IMM_WIDTH'(8'd35);
      default:    coef = '0;
    endcase
  endfunction

  // Parity travels inside the instruction register so it is always held with the fields.
  function automatic instr_t mk(input logic [OPCODE_WIDTH-1:0] op,
                                input logic [IMM_WIDTH-1:0] imm);
    instr_t v;
    v.op  = op;
    v.imm = imm;
`ifdef GAUSS_INSTR_PARITY_EN
    v.par = ^{op, imm};
`endif
    return v;
  endfunction

  state_t      r_state;
  logic [2:0]  r_tap;
  logic [7:0]  r_pix;
  logic [7:0]  r_n_pix;
  logic        r_abort;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  instr_t      r_instr;

  logic        w_xfer;
  logic        w_abort;

  assign w_xfer  = r_valid & instr_ready;
  assign w_abort = r_abort | abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_tap   <= '0;
      r_pix   <= '0;
      r_n_pix <= '0;
      r_abort <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_instr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_n_pix <= n_pix;
            r_tap   <= '0;
            r_pix   <= '0;
            r_abort <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            if (n_pix == 8'd0) begin
              r_state <= StEnd;
              r_instr <= mk(OpEnd, '0);
            end else begin
              r_state <= StMul;
              r_instr <= mk(OpMul, coef(3'd0));
            end
          end
        end
        StMul: begin
          if (w_xfer) begin
            if (w_abort) begin
              r_state <= StEnd;
              r_instr <= mk(OpEnd, '0);
            end else begin
              r_state <= StAdd;
              r_instr <= mk(OpAdd, '0);
            end
          end else if (abort) begin
            r_abort <= 1'b1;
          end
        end
        StAdd: begin
          if (w_xfer) begin
            if (w_abort || (r_tap == 3'd4 && r_pix == r_n_pix - 8'd1)) begin
              r_state <= StEnd;
              r_instr <= mk(OpEnd, '0);
            end else if (r_tap == 3'd4) begin
              r_tap   <= '0;
              r_pix   <= r_pix + 8'd1;
              r_state <= StMul;
              r_instr <= mk(OpMul, coef(3'd0));
            end else begin
              r_tap   <= r_tap + 3'd1;
              r_state <= StMul;
              r_instr <= mk(OpMul, coef(r_tap + 3'd1));
            end
          end else if (abort) begin
            r_abort <= 1'b1;
          end
        end
        StEnd: begin
          if (w_xfer) begin
            r_state <= StDone;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_instr <= '0;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign instr_valid  = r_valid;
  assign instr_opcode = r_instr.op;
  assign instr_imm    = r_instr.imm;
`ifdef GAUSS_INSTR_PARITY_EN
  assign instr_par    = r_instr.par;
`endif
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_gauss_instr_gen.sv
// Directed bench for gauss_instr_gen: program order, handshake stalls, abort, reset, back-to-back.
module tb_gauss_instr_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] n_pix;
  logic       abort;
  logic       instr_valid;
  logic       instr_ready;
  logic [5:0] instr_opcode;
  logic [7:0] instr_imm;
`ifdef GAUSS_INSTR_PARITY_EN
  logic       instr_par;
`endif
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  logic [5:0] q_op[$];
  logic [7:0] q_imm[$];
  logic       q_par[$];
  int         done_cyc;
  int         busy_cyc;
  int         stab_err;
  logic [15:0] pat = 16'b1011_0010_1110_0101;

  gauss_instr_gen #(.OPCODE_WIDTH(6), .IMM_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .n_pix        (n_pix),
    .abort        (abort),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_imm    (instr_imm),
`ifdef GAUSS_INSTR_PARITY_EN
    .instr_par    (instr_par),
`endif
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] kern(input int i);
    case (i)
      0, 4:    return 8'd17;
      1, 3:    return 8'd29;
      default: return 8'd35;
    endcase
  endfunction

  function automatic logic [5:0] exp_op(input int idx, input int n);
    if (idx >= 10 * n) return 6'd3;
    return (idx % 2 == 0) ? 6'd1 : 6'd2;
  endfunction

  function automatic logic [7:0] exp_imm(input int idx, input int n);
    if (idx >= 10 * n || idx % 2 == 1) return 8'd0;
    return kern((idx / 2) % 5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; instr_ready = 1'b0; n_pix = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push_xfer();
    q_op.push_back(instr_opcode);
    q_imm.push_back(instr_imm);
`ifdef GAUSS_INSTR_PARITY_EN
    q_par.push_back(instr_par);
`else
    q_par.push_back(1'b0);
`endif
  endtask

  // Starts a program and records transfers; no comparisons are made here.
  task automatic run_prog(input int n, input int mode, input int restart_at,
                          input logic abort_with_start, input int budget);
    logic       hold = 1'b0;
    logic [5:0] h_op = '0;
    logic [7:0] h_imm = '0;
    int         cyc;
    q_op.delete(); q_imm.delete(); q_par.delete();
    done_cyc = -1; busy_cyc = 0; stab_err = 0;
    start = 1'b1; n_pix = 8'(n); abort = abort_with_start;
    step();
    start = 1'b0; abort = 1'b0;
    cyc = 1;
    while (cyc <= budget) begin
      start = (cyc == restart_at);
      if (start) n_pix = 8'd3;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy) busy_cyc++;
      if (hold && (instr_valid !== 1'b1 || instr_opcode !== h_op || instr_imm !== h_imm))
        stab_err++;
      instr_ready = (mode == 0) ? 1'b1 : pat[cyc % 16];
      if (instr_valid && instr_ready) push_xfer();
      hold = instr_valid && !instr_ready;
      h_op = instr_opcode; h_imm = instr_imm;
      step();
      cyc++;
    end
    start = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instr_opcode !== 6'd0) begin failures++; $display("FAIL reset_opcode: got %0d expected 0", instr_opcode); end
    checks++; if (instr_imm !== 8'd0) begin failures++; $display("FAIL reset_imm: got %0d expected 0", instr_imm); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_hold: got valid=%b busy=%b expected 0 0", instr_valid, busy); end
  endtask

  task automatic test_single_pixel();
    do_reset();
    run_prog(1, 0, -1, 1'b0, 40);
    checks++; if (q_op.size() != 11) begin failures++; $display("FAIL p1_count: got %0d expected 11", q_op.size()); end
    for (int i = 0; i < q_op.size() && i < 11; i++) begin
      checks++;
      if (q_op[i] !== exp_op(i, 1) || q_imm[i] !== exp_imm(i, 1)) begin
        failures++;
        $display("FAIL p1_seq[%0d]: got op=%0d imm=%0d expected op=%0d imm=%0d",
                 i, q_op[i], q_imm[i], exp_op(i, 1), exp_imm(i, 1));
      end
    end
`ifdef GAUSS_INSTR_PARITY_EN
    if (q_par.size() >= 11) begin
      checks++; if (q_par[0] !== 1'b1) begin failures++; $display("FAIL par_mul17: got %b expected 1", q_par[0]); end
      checks++; if (q_par[10] !== 1'b0) begin failures++; $display("FAIL par_end: got %b expected 0", q_par[10]); end
    end
`endif
    checks++; if (done_cyc != 12) begin failures++; $display("FAIL p1_done_cycle: got %0d expected 12", done_cyc); end
    checks++; if (busy_cyc != 11) begin failures++; $display("FAIL p1_busy_cycles: got %0d expected 11", busy_cyc); end
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL p1_at_done: got busy=%b valid=%b expected 0 0", busy, instr_valid); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL p1_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_ready_toggle();
    do_reset();
    run_prog(3, 1, -1, 1'b0, 300);
    checks++; if (q_op.size() != 31) begin failures++; $display("FAIL p3_count: got %0d expected 31", q_op.size()); end
    for (int i = 0; i < q_op.size() && i < 31; i++) begin
      checks++;
      if (q_op[i] !== exp_op(i, 3) || q_imm[i] !== exp_imm(i, 3)) begin
        failures++;
        $display("FAIL p3_seq[%0d]: got op=%0d imm=%0d expected op=%0d imm=%0d",
                 i, q_op[i], q_imm[i], exp_op(i, 3), exp_imm(i, 3));
      end
    end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL p3_stable: got %0d unstable cycles expected 0", stab_err); end
    checks++; if (done_cyc < 32) begin failures++; $display("FAIL p3_done: got cycle %0d expected >= 32", done_cyc); end
  endtask

  task automatic test_zero_pix();
    do_reset();
    run_prog(0, 0, -1, 1'b0, 20);
    checks++; if (q_op.size() != 1) begin failures++; $display("FAIL p0_count: got %0d expected 1", q_op.size()); end
    if (q_op.size() >= 1) begin
      checks++; if (q_op[0] !== 6'd3 || q_imm[0] !== 8'd0) begin failures++; $display("FAIL p0_end: got op=%0d imm=%0d expected op=3 imm=0", q_op[0], q_imm[0]); end
    end
    checks++; if (done_cyc != 2) begin failures++; $display("FAIL p0_done_cycle: got %0d expected 2", done_cyc); end
    checks++; if (busy_cyc != 1) begin failures++; $display("FAIL p0_busy_cycles: got %0d expected 1", busy_cyc); end
  endtask

  task automatic test_start_ignored();
    do_reset();
    run_prog(1, 0, 3, 1'b1, 40);
    checks++; if (q_op.size() != 11) begin failures++; $display("FAIL ign_count: got %0d expected 11", q_op.size()); end
    checks++; if (done_cyc != 12) begin failures++; $display("FAIL ign_done_cycle: got %0d expected 12", done_cyc); end
  endtask

  task automatic test_abort();
    int   phase = 0;
    int   w = 0;
    int   held_bad = 0;
    logic done_seen = 1'b0;
    do_reset();
    q_op.delete(); q_imm.delete(); q_par.delete();
    start = 1'b1; n_pix = 8'd2; instr_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      abort = 1'b0;
      if (phase == 0 && instr_valid && instr_opcode == 6'd1 && instr_imm == 8'd35) begin
        phase = 1; instr_ready = 1'b0; abort = 1'b1;
      end else if (phase == 1) begin
        w++;
        if (!(instr_valid && instr_opcode == 6'd1 && instr_imm == 8'd35)) held_bad++;
        if (w == 3) begin
          instr_ready = 1'b1; phase = 2;
        end
      end
      if (instr_valid && instr_ready) push_xfer();
      step();
    end
    abort = 1'b0; instr_ready = 1'b0;
    checks++; if (phase != 2) begin failures++; $display("FAIL ab_reached: got phase %0d expected 2", phase); end
    checks++; if (q_op.size() != 6) begin failures++; $display("FAIL ab_count: got %0d expected 6", q_op.size()); end
    for (int i = 0; i < q_op.size() && i < 6; i++) begin
      checks++;
      if (q_op[i] !== exp_op((i == 5) ? 20 : i, 2) || q_imm[i] !== exp_imm((i == 5) ? 20 : i, 2)) begin
        failures++;
        $display("FAIL ab_seq[%0d]: got op=%0d imm=%0d expected op=%0d imm=%0d", i, q_op[i],
                 q_imm[i], exp_op((i == 5) ? 20 : i, 2), exp_imm((i == 5) ? 20 : i, 2));
      end
    end
    checks++; if (held_bad != 0) begin failures++; $display("FAIL ab_held: got %0d bad cycles expected 0", held_bad); end
    checks++; if (done_seen !== 1'b1) begin failures++; $display("FAIL ab_done: got %b expected 1", done_seen); end
  endtask

  task automatic test_mid_reset();
    int   xfers = 0;
    logic hit = 1'b0;
    do_reset();
    start = 1'b1; n_pix = 8'd2; instr_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (xfers >= 10 && instr_valid && instr_opcode == 6'd2) begin
        hit = 1'b1;
        break;
      end
      if (instr_valid && instr_ready) xfers++;
      step();
    end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL mr_reached: got %b expected 1", hit); end
    if (hit) begin
      reset = 1'b1;
      step();
      checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mr_cleared: got valid=%b busy=%b expected 0 0", instr_valid, busy); end
      reset = 1'b0;
    end
    instr_ready = 1'b0;
    run_prog(1, 0, -1, 1'b0, 40);
    checks++; if (q_op.size() != 11) begin failures++; $display("FAIL mr_count: got %0d expected 11", q_op.size()); end
    if (q_op.size() >= 1) begin
      checks++; if (q_op[0] !== 6'd1 || q_imm[0] !== 8'd17) begin failures++; $display("FAIL mr_first: got op=%0d imm=%0d expected op=1 imm=17", q_op[0], q_imm[0]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_prog(0, 0, -1, 1'b0, 20);
    step();
    run_prog(1, 0, -1, 1'b0, 40);
    checks++; if (q_op.size() != 11) begin failures++; $display("FAIL b2b_count: got %0d expected 11", q_op.size()); end
    checks++; if (done_cyc != 12) begin failures++; $display("FAIL b2b_done_cycle: got %0d expected 12", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_ready_toggle();
    test_zero_pix();
    test_start_ignored();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gauss_instr_gen.md
# gauss_instr_gen

Instruction-stream generator for the 5-tap Gaussian filter datapath. It encodes the MUL/ADD/END opcode stream, with kernel coefficients as immediates, that the picoMIPS core decodes and executes. It sits upstream of the core's instruction input and replaces a hand-written program ROM for the filter loop. It delivers one instruction per accepted valid/ready handshake.

## Interface
- OPCODE_WIDTH, 6, opcode field width; must match the core's decoder.
- IMM_WIDTH, 8, immediate field width; must match the kernel coefficient width.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a program; sampled only in IDLE.
- n_pix  in  8  number of output pixels; sampled on an accepted start.
- abort  in  1  request early termination; sampled every cycle while busy.
- instr_valid  out  1  instruction fields are valid.
- instr_ready  in  1  the core accepts the instruction this cycle.
- instr_opcode  out  OPCODE_WIDTH  opcode: MUL=6'b000001, ADD=6'b000010, END=6'b000011.
- instr_imm  out  IMM_WIDTH  immediate: kernel coefficient for MUL, 0 for ADD and END.
- busy  out  1  high from the cycle after an accepted start until END is accepted.
- done  out  1  one-cycle pulse in the cycle after END is accepted.

## Operation
- Kernel constants: K = {17, 29, 35, 29, 17}, fixed at 8 bits. Index 0 is emitted first.
- Program emitted for each pixel p = 0..n_pix-1, taps i = 0..4: MUL imm=K[i], then ADD imm=0. That is 10 instructions per pixel.
- After the last pixel, one END with imm=0 is emitted. Total transfers = 10*n_pix + 1.
- n_pix = 0: only END is emitted.
- State machine:
  - IDLE: start goes to MUL, or to END if n_pix = 0. Counters are cleared.
  - MUL: on transfer, go to ADD.
  - ADD: on transfer, tap increments.
    - tap = 4 and pix = n_pix-1: go to END.
    - tap = 4 otherwise: tap clears, pix increments, go to MUL.
    - otherwise: go to MUL.
  - END: on transfer, go to DONE.
  - DONE: pulses done for one cycle, then goes to IDLE.
- Counters: tap is 3 bits (0..4, never 5–7). pix is 8 bits and is compared against the latched n_pix, so it never wraps.
- Handshake: a transfer occurs on an edge where instr_valid & instr_ready = 1.
  - While valid is high and no transfer occurs, opcode and imm hold stable.
  - valid never drops without a transfer, except on reset.
- Abort:
  - In MUL or ADD with no transfer that cycle, abort sets a sticky pending flag. The held instruction is not withdrawn.
  - When a transfer occurs and abort is either pending or asserted that cycle, the next state is END regardless of counters.
  - Abort in END, DONE or IDLE is ignored.
- start while busy is ignored. start and abort in the same IDLE cycle: start is accepted and abort is ignored.
- reset at any point: go to IDLE, clear counters and the abort flag, and drop instr_valid immediately at that edge.

## Timing
- Reset values: instr_valid=0, instr_opcode=0, instr_imm=0, busy=0, done=0.
- All outputs are registered.
- Start accepted at edge t: instr_valid=1 with MUL/17 from t+1, and busy=1 from t+1.
- With instr_ready held high, one instruction transfers per cycle with no bubbles. The next instruction is presented in the cycle after each transfer.
- END accepted at edge e: done=1 and busy=0 during cycle e+1, instr_valid=0 from e+1.
- A new start is accepted earliest at edge e+2, i.e. once back in IDLE.
- Start-to-done latency with ready always high: 10*n_pix + 2 cycles.

## Configuration
- GAUSS_INSTR_PARITY_EN
  - Defined: adds output port instr_par (1 bit, registered, reset 0), equal to the even parity (XOR) of {instr_opcode, instr_imm}. It is valid whenever instr_valid is high and held with the instruction.
  - Undefined: the port does not exist and behaviour is otherwise identical.

## Test plan
- n_pix=1, ready always high, start pulse → exactly 11 transfers: MUL17, ADD0, MUL29, ADD0, MUL35, ADD0, MUL29, ADD0, MUL17, ADD0, END0. done pulses 12 cycles after start.
- n_pix=3, ready toggling pseudo-randomly → 31 transfers in the same order. Fields remain stable on every cycle where valid=1 and ready=0. No transfer is duplicated or lost.
- n_pix=0 → a single END transfer, then done. busy is high for exactly the END cycles.
- n_pix=2, ready=0 while MUL35 of pixel 0 is presented, abort pulsed for 1 cycle, ready raised 3 cycles later → MUL35 transfers, then END, then done. No further MUL/ADD is emitted.
- reset asserted mid-program (pixel 1, ADD) → instr_valid=0 and busy=0 on the next cycle. A subsequent start with n_pix=1 emits MUL17 first.
- With GAUSS_INSTR_PARITY_EN defined, n_pix=1 → instr_par=1 for MUL17 (6'b000001, 8'h11: three ones). instr_par=0 for END (6'b000011, 0: two ones).
